mem_stage: RTL and testbench

- MIPS MEM stage that sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs data-memory loads and stores against an internal word-addressed RAM with a configurable access latency.
- Asserts a stall to the upstream pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register outputs to the writeback stage, plus a writeback-data value for forwarding.

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// MIPS MEM stage. It sits directly after the EX/MEM pipeline register and
// performs loads and stores against an internal word-addressed RAM whose
// access takes MEM_LAT cycles. While an access is outstanding, the stage
// raises `stall` so the upstream stages hold the EX/MEM contents. The stage
// also drives the MEM/WB pipeline register fields, and it exposes a
// writeback value (`wbdata`) that the forwarding paths can use.
//
// Handshake: whenever `stall` is high, the upstream pipeline must present
// the same EX/MEM values on every cycle. The access commits on the first
// edge where `stall` is low for that request. Non-memory instructions and
// misaligned accesses never stall and pass to MEM/WB after one edge.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   memwrite, memread    store / load request from EX/MEM
//   memtoreg, regwrite   writeback controls from EX/MEM
//   writereg             destination register
//   aluresult            byte address (memory ops) or ALU result
//   readreg2             store data
//   stall                combinational hold request to upstream
//   regwriteo, memtorego, readdatao, aluresulto, rdo   MEM/WB fields
//   misalign             one-cycle flag for a misaligned access
//   wbdata               combinational writeback/forwarding value
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic        memread,
  input  logic        memtoreg,
  input  logic        regwrite,
  input  logic [4:0]  writereg,
  input  logic [31:0] aluresult,
  input  logic [31:0] readreg2,
  output logic        stall,
  output logic        regwriteo,
  output logic        memtorego,
  output logic [31:0] readdatao,
  output logic [31:0] aluresulto,
  output logic [4:0]  rdo,
  output logic        misalign,
  output logic [31:0] wbdata
);

  // Value of the access counter on the cycle an access commits.
  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              access;
  logic              aligned;
  logic              req;
  logic              mis;
  logic              commit;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;

  // The access counter is the FSM state: cnt_q == 0 is IDLE and any other
  // value is WAIT.
  logic [3:0]  cnt_q,       cnt_d;
  logic        regwrite_q,  regwrite_d;
  logic        memtoreg_q,  memtoreg_d;
  logic [31:0] readdata_q,  readdata_d;
  logic [31:0] aluresult_q, aluresult_d;
  logic [4:0]  rd_q,        rd_d;
  logic        misalign_q,  misalign_d;
  logic        mem_we;

  logic [31:0] mem_q [DEPTH];

  assign access  = memread | memwrite;
  assign aligned = (aluresult[1:0] == 2'b00);
  assign req     = access & aligned;
  assign mis     = access & ~aligned;
  assign commit  = req & (cnt_q == CNT_LAST);

  // The upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign idx     = aluresult[ADDR_W+1:2];
  assign rd_word = mem_q[idx];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      readdata_q  <= 32'd0;
      aluresult_q <= 32'd0;
      rd_q        <= 5'd0;
      misalign_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      readdata_q  <= readdata_d;
      aluresult_q <= aluresult_d;
      rd_q        <= rd_d;
      misalign_q  <= misalign_d;
    end
  end

  // The data RAM is never reset. The write enable already excludes reset,
  // so an abandoned store leaves the RAM unchanged.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= readreg2;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    readdata_d  = readdata_q;
    aluresult_d = aluresult_q;
    rd_d        = rd_q;
    misalign_d  = 1'b0;

    if (commit) begin
      cnt_d       = 4'd0;
      regwrite_d  = regwrite;
      memtoreg_d  = memtoreg;
      aluresult_d = aluresult;
      rd_d        = writereg;
      // When memread and memwrite are both set, the access is treated as a
      // store, and a store returns no load data.
      readdata_d  = memwrite ? 32'd0 : rd_word;
    end else if (req) begin
      // Still waiting: the counter advances, and a bubble goes to writeback.
      cnt_d       = cnt_q + 4'd1;
      regwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
    end else begin
      // Plain pipeline-register behaviour. A misaligned access also takes
      // this path, but it is squashed so it never writes back.
      cnt_d       = 4'd0;
      regwrite_d  = regwrite & ~mis;
      memtoreg_d  = memtoreg & ~mis;
      aluresult_d = aluresult;
      rd_d        = writereg;
      readdata_d  = 32'd0;
      misalign_d  = mis;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall  = ~rst & req & (cnt_q != CNT_LAST);
    mem_we = ~rst & commit & memwrite;
    wbdata = memtoreg_q ? readdata_q : aluresult_q;
  end

  assign regwriteo  = regwrite_q;
  assign memtorego  = memtoreg_q;
  assign readdatao  = readdata_q;
  assign aluresulto = aluresult_q;
  assign rdo        = rd_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. It uses two instances: one with MEM_LAT=2
// and one with MEM_LAT=1. Both instances share the clock and the reset.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Inputs of the MEM_LAT=2 instance
  logic        memwrite, memread, memtoreg, regwrite;
  logic [4:0]  writereg;
  logic [31:0] aluresult, readreg2;
  // Outputs of the MEM_LAT=2 instance
  logic        stall, regwriteo, memtorego, misalign;
  logic [31:0] readdatao, aluresulto, wbdata;
  logic [4:0]  rdo;

  // Inputs of the MEM_LAT=1 instance
  logic        memwrite1, memread1, memtoreg1, regwrite1;
  logic [4:0]  writereg1;
  logic [31:0] aluresult1, readreg21;
  // Outputs of the MEM_LAT=1 instance
  logic        stall1, regwriteo1, memtorego1, misalign1;
  logic [31:0] readdatao1, aluresulto1, wbdata1;
  logic [4:0]  rdo1;

  mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg),
    .regwrite(regwrite), .writereg(writereg), .aluresult(aluresult),
    .readreg2(readreg2), .stall(stall), .regwriteo(regwriteo),
    .memtorego(memtorego), .readdatao(readdatao), .aluresulto(aluresulto),
    .rdo(rdo), .misalign(misalign), .wbdata(wbdata)
  );

  mem_stage #(.DEPTH(256), .ADDR_W(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .memwrite(memwrite1), .memread(memread1), .memtoreg(memtoreg1),
    .regwrite(regwrite1), .writereg(writereg1), .aluresult(aluresult1),
    .readreg2(readreg21), .stall(stall1), .regwriteo(regwriteo1),
    .memtorego(memtorego1), .readdatao(readdatao1), .aluresulto(aluresulto1),
    .rdo(rdo1), .misalign(misalign1), .wbdata(wbdata1)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic mw, input logic mr, input logic mtr,
                       input logic rw, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd2);
    memwrite = mw; memread = mr; memtoreg = mtr; regwrite = rw;
    writereg = wr; aluresult = alu; readreg2 = rd2;
    #1;
  endtask

  task automatic drive1(input logic mw, input logic mr, input logic mtr,
                        input logic rw, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] rd2);
    memwrite1 = mw; memread1 = mr; memtoreg1 = mtr; regwrite1 = rw;
    writereg1 = wr; aluresult1 = alu; readreg21 = rd2;
    #1;
  endtask

  // Advance one cycle, then sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a two-cycle memory access on the MEM_LAT=2 instance and check
  // the stall and bubble cycle. On return, the commit edge has just passed.
  task automatic mem_access2(input string tag, input logic mw, input logic mr,
                             input logic mtr, input logic rw,
                             input logic [4:0] wr, input logic [31:0] alu,
                             input logic [31:0] rd2);
    drive(mw, mr, mtr, rw, wr, alu, rd2);
    check_eq({tag, "_stall_first"}, 32'(stall), 32'd1);
    tick();
    check_eq({tag, "_bubble_rw"}, 32'(regwriteo), 32'd0);
    check_eq({tag, "_stall_last"}, 32'(stall), 32'd0);
    tick();
  endtask

  // Table of instructions for the MEM_LAT=1 instance.
  localparam int N1 = 5;
  logic        t_mw  [N1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        t_mr  [N1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        t_mtr [N1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        t_rw  [N1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0]  t_wr  [N1] = '{5'd1, 5'd9, 5'd12, 5'd2, 5'd14};
  logic [31:0] t_alu [N1] = '{32'h40, 32'h40, 32'h77, 32'h44, 32'h44};
  logic [31:0] t_rd2 [N1] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0BADF00D, 32'h0};
  // Expected MEM/WB values after each entry. Loads return the data that the
  // earlier store in the table wrote; all other entries carry readdata 0.
  logic [31:0] e_rdata [N1] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0BADF00D};
  logic [31:0] e_wb    [N1] = '{32'h40, 32'hCAFEF00D, 32'h77, 32'h44, 32'h0BADF00D};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    // Reset state, with an aligned load already presented.
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_regwriteo", 32'(regwriteo), 32'd0);
    check_eq("rst_rdo", 32'(rdo), 32'd0);
    check_eq("rst_aluresulto", aluresulto, 32'd0);
    check_eq("rst_wbdata", wbdata, 32'd0);
    rst = 1'b0;

    // 1: non-memory instruction
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
    check_eq("alu_stall", 32'(stall), 32'd0);
    tick();
    check_eq("alu_rdo", 32'(rdo), 32'd5);
    check_eq("alu_aluresulto", aluresulto, 32'h1234);
    check_eq("alu_regwriteo", 32'(regwriteo), 32'd1);
    check_eq("alu_wbdata", wbdata, 32'h1234);
    check_eq("alu_misalign", 32'(misalign), 32'd0);

    // 2: store, then load back from the same address
    mem_access2("st10", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF);
    check_eq("st10_regwriteo", 32'(regwriteo), 32'd0);
    mem_access2("ld10", 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h10, 32'h0);
    check_eq("ld10_readdatao", readdatao, 32'hDEADBEEF);
    check_eq("ld10_rdo", 32'(rdo), 32'd8);
    check_eq("ld10_regwriteo", 32'(regwriteo), 32'd1);
    check_eq("ld10_memtorego", 32'(memtorego), 32'd1);
    check_eq("ld10_wbdata", wbdata, 32'hDEADBEEF);

    // 3: address wrap. Byte address 0x400 maps to word index 0.
    mem_access2("st400", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h400, 32'hA5A5A5A5);
    mem_access2("ld0", 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0, 32'h0);
    check_eq("wrap_readdatao", readdatao, 32'hA5A5A5A5);

    // 4: misaligned load
    drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h13, 32'h0);
    check_eq("mis_stall", 32'(stall), 32'd0);
    tick();
    check_eq("mis_flag", 32'(misalign), 32'd1);
    check_eq("mis_regwriteo", 32'(regwriteo), 32'd0);
    check_eq("mis_memtorego", 32'(memtorego), 32'd0);
    check_eq("mis_readdatao", readdatao, 32'd0);
    check_eq("mis_aluresulto", aluresulto, 32'h13);
    check_eq("mis_rdo", 32'(rdo), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    check_eq("mis_flag_clear", 32'(misalign), 32'd0);

    // Illegal memread and memwrite together: treated as a store.
    mem_access2("both30", 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h30, 32'h55AA55AA);
    check_eq("both30_readdatao", readdatao, 32'd0);
    mem_access2("ld30", 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h30, 32'h0);
    check_eq("ld30_readdatao", readdatao, 32'h55AA55AA);

    // 5: reset during a pending store
    mem_access2("st20a", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11111111);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h20, 32'h22222222);
    check_eq("st20b_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_stall", 32'(stall), 32'd0);
    check_eq("midrst_rdo", 32'(rdo), 32'd0);
    check_eq("midrst_aluresulto", aluresulto, 32'd0);
    check_eq("midrst_readdatao", readdatao, 32'd0);
    check_eq("midrst_wbdata", wbdata, 32'd0);
    tick();
    check_eq("midrst_hold_regwriteo", 32'(regwriteo), 32'd0);
    rst = 1'b0;
    mem_access2("ld20", 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h20, 32'h0);
    check_eq("ld20_readdatao", readdatao, 32'h11111111);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    // 6: the MEM_LAT=1 instance never stalls and has a latency of one cycle.
    for (int i = 0; i < N1; i++) begin
      drive1(t_mw[i], t_mr[i], t_mtr[i], t_rw[i], t_wr[i], t_alu[i], t_rd2[i]);
      check_eq($sformatf("lat1_%0d_stall", i), 32'(stall1), 32'd0);
      tick();
      check_eq($sformatf("lat1_%0d_rdo", i), 32'(rdo1), 32'(t_wr[i]));
      check_eq($sformatf("lat1_%0d_regwriteo", i), 32'(regwriteo1), 32'(t_rw[i]));
      check_eq($sformatf("lat1_%0d_aluresulto", i), aluresulto1, t_alu[i]);
      check_eq($sformatf("lat1_%0d_readdatao", i), readdatao1, e_rdata[i]);
      check_eq($sformatf("lat1_%0d_wbdata", i), wbdata1, e_wb[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog, in case the stimulus ever stops making progress.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
